exp_taylor_engine: RTL and testbench

//  Iterative e^x evaluator that consumes the 1/n reciprocal LUT, which is

---
 rtl/exp_taylor_engine.sv | 145 ++++++++++++++
 tb/tb_exp_taylor_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_taylor_engine.sv
// exp_taylor_engine: iterative e^x evaluator over a truncated Taylor series.
//  Each series term takes two cycles. MUL_X multiplies the term by x. MUL_R
//  multiplies it by 1/k and adds the product to the running sum.
//  The external reciprocal LUT maps address n to 1/(n+1) in Q0.16, with
//  address 0 returning 0xFFFF.
// Ports:
//  clk       in   rising-edge clock
//  rst       in   asynchronous active-high reset
//  start     in   request, sampled only while idle
//  x         in   operand, unsigned Q0.16, latched on an accepted start
//  lut_adr   out  reciprocal LUT address; nonzero only in MUL_R
//  lut_data  in   reciprocal LUT data, Q0.16, consumed in the same cycle
//  busy      out  high from the cycle after accept through the done cycle
//  done      out  one-cycle completion pulse
//  result    out  e^x, unsigned Q2.16, held until the next completion
module exp_taylor_engine #(
    parameter int unsigned N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x,
    output logic [3:0]  lut_adr,
    input  logic [15:0] lut_data,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    localparam int unsigned X_W    = 16;
    localparam int unsigned TERM_W = 17;
    localparam int unsigned SUM_W  = 18;
    localparam int unsigned K_W    = 5;
    localparam int unsigned ADR_W  = 4;
    localparam int unsigned PROD_W = 33;
    localparam int unsigned FRAC_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL_X = 2'd1,
        S_MUL_R = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [X_W-1:0]      xr, xr_n;
    logic [TERM_W-1:0]   term, term_n;
    logic [SUM_W-1:0]    sum, sum_n;
    logic [K_W-1:0]      k, k_n;
    logic [ADR_W-1:0]    lut_adr_n;
    logic                busy_n, done_n;
    logic [SUM_W-1:0]    result_n;

    logic [X_W-1:0]      lut_q;
    logic [PROD_W-1:0]   prod_x, prod_r;
    logic [TERM_W-1:0]   term_x, term_r;
    logic [SUM_W-1:0]    sum_r;

    // LUT data is masked outside MUL_R so an undriven ROM output cannot reach state
    assign lut_q  = (state == S_MUL_R) ? lut_data : '0;
    assign prod_x = PROD_W'(term) * PROD_W'(xr);
    assign prod_r = PROD_W'(term) * PROD_W'(lut_q);
    assign term_x = TERM_W'(prod_x >> FRAC_W);
    assign term_r = TERM_W'(prod_r >> FRAC_W);
    assign sum_r  = sum + SUM_W'(term_r);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            xr      <= '0;
            term    <= '0;
            sum     <= '0;
            k       <= '0;
            lut_adr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_n;
            xr      <= xr_n;
            term    <= term_n;
            sum     <= sum_n;
            k       <= k_n;
            lut_adr <= lut_adr_n;
            busy    <= busy_n;
            done    <= done_n;
            result  <= result_n;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle early so
    // that the registered values line up with the state they belong to.
    always_comb begin
        state_n   = state;
        xr_n      = xr;
        term_n    = term;
        sum_n     = sum;
        k_n       = k;
        lut_adr_n = '0;
        busy_n    = busy;
        done_n    = 1'b0;
        result_n  = result;

        case (state)
            S_IDLE: begin
                if (start) begin
                    xr_n    = x;
                    term_n  = TERM_W'(17'h10000);
                    sum_n   = SUM_W'(18'h10000);
                    k_n     = K_W'(1);
                    busy_n  = 1'b1;
                    state_n = S_MUL_X;
                end
            end
            S_MUL_X: begin
                term_n    = term_x;
                // 1/k lives at LUT address k-1 and must be presented during MUL_R
                lut_adr_n = ADR_W'(k - K_W'(1));
                state_n   = S_MUL_R;
            end
            S_MUL_R: begin
                term_n = term_r;
                sum_n  = sum_r;
                if (k == K_W'(N_TERMS)) begin
                    // result is loaded on entry to DONE so it is valid alongside done
                    result_n = sum_r;
                    done_n   = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    k_n     = k + K_W'(1);
                    state_n = S_MUL_X;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_exp_taylor_engine.sv
// tb_exp_taylor_engine: scoreboard bench for exp_taylor_engine.
//  Two instances are used: N_TERMS=8 (default) and N_TERMS=1. Each one has its
//  own reciprocal ROM model. Stimulus pushes hand-computed results and accept
//  cycles into per-instance queues. Monitors pop a queue entry on each done.
module tb_exp_taylor_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start1;
    logic [15:0] x8, x1;
    logic [3:0]  lut_adr8, lut_adr1;
    logic [15:0] lut_data8, lut_data1;
    logic        busy8, busy1, done8, done1;
    logic [17:0] result8, result1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    logic chk_busy8 = 1'b0;
    logic chk_busy1 = 1'b0;

    typedef struct {
        logic [17:0] res;
        int          acc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] recip(input logic [3:0] a);
        if (a == 4'd0) return 16'hFFFF;
        return 16'(32'd65536 / (32'(a) + 32'd1));
    endfunction

    assign lut_data8 = recip(lut_adr8);
    assign lut_data1 = recip(lut_adr1);

    exp_taylor_engine #(.N_TERMS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8),
        .lut_adr(lut_adr8), .lut_data(lut_data8),
        .busy(busy8), .done(done8), .result(result8)
    );

    exp_taylor_engine #(.N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x(x1),
        .lut_adr(lut_adr1), .lut_data(lut_data1),
        .busy(busy1), .done(done1), .result(result1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy8"}, 32'(busy8), 32'd0);
        check({tag, "_done8"}, 32'(done8), 32'd0);
        check({tag, "_result8"}, 32'(result8), 32'd0);
        check({tag, "_lut_adr8"}, 32'(lut_adr8), 32'd0);
        check({tag, "_busy1"}, 32'(busy1), 32'd0);
        check({tag, "_result1"}, 32'(result1), 32'd0);
    endtask

    // Monitor for the N_TERMS=8 instance
    always @(negedge clk) begin
        exp_t e;
        if (chk_busy8) begin
            check("busy8_after_done", 32'(busy8), 32'd0);
            chk_busy8 = 1'b0;
        end
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                e = q8.pop_front();
                check("result8", 32'(result8), 32'(e.res));
                check("latency8", 32'(cyc - e.acc), 32'd16);
            end
            chk_busy8 = 1'b1;
        end
    end

    // Monitor for the N_TERMS=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (chk_busy1) begin
            check("busy1_after_done", 32'(busy1), 32'd0);
            chk_busy1 = 1'b0;
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                e = q1.pop_front();
                check("result1", 32'(result1), 32'(e.res));
                check("latency1", 32'(cyc - e.acc), 32'd2);
            end
            chk_busy1 = 1'b1;
        end
    end

    task automatic wait_idle(input int which);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (which == 8 && q8.size() == 0 && !busy8 && !done8) return;
            if (which == 1 && q1.size() == 0 && !busy1 && !done1) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_dut%0d: got no completion expected done within 60 cycles", which);
    endtask

    task automatic run8(input logic [15:0] xv, input logic [17:0] res);
        @(negedge clk);
        start8 = 1'b1;
        x8 = xv;
        q8.push_back('{res: res, acc: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        x8 = 16'h1234;
        wait_idle(8);
    endtask

    task automatic run1(input logic [15:0] xv, input logic [17:0] res);
        @(negedge clk);
        start1 = 1'b1;
        x1 = xv;
        q1.push_back('{res: res, acc: cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
        x1 = 16'h4321;
        wait_idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int a;
        rst = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        x8 = '0;
        x1 = '0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // e^0.25 with truncation: 65536+16383+2047+170+10 = 84146
        run8(16'h4000, 18'h148B2);

        // Asynchronous reset mid-cycle clears the held result without a clock edge
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("async");
        @(negedge clk);
        rst = 1'b0;

        // x=0 leaves only term_0
        run8(16'h0000, 18'h10000);

        // e^0.5 with the LUT address sequence checked on every cycle of the run
        @(negedge clk);
        start8 = 1'b1;
        x8 = 16'h8000;
        a = cyc + 1;
        q8.push_back('{res: 18'h1A60D, acc: a});
        @(negedge clk);
        start8 = 1'b0;
        for (int d = 0; d <= 16; d++) begin
            if (d > 0) @(negedge clk);
            check($sformatf("lut_adr_d%0d", d), 32'(lut_adr8),
                  (d % 2 == 1) ? 32'((d - 1) / 2) : 32'd0);
        end
        wait_idle(8);

        // Largest operand: exact truncated sum and the bound below e
        run8(16'hFFFF, 18'h2B7D7);
        check("ffff_not_above_e", 32'(result8 <= 18'h2B7E1), 32'd1);
        check("ffff_within_32lsb", 32'(result8 >= 18'h2B7C1), 32'd1);

        // start held high while x changes mid-run; the second run picks up the new x
        @(negedge clk);
        start8 = 1'b1;
        x8 = 16'h8000;
        a = cyc + 1;
        q8.push_back('{res: 18'h1A60D, acc: a});
        repeat (5) @(negedge clk);
        x8 = 16'hFFFF;
        while (cyc < a + 17) @(negedge clk);
        q8.push_back('{res: 18'h2B7D7, acc: cyc + 1});
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(8);

        // Reset during MUL_R of term 4, then a clean run
        @(negedge clk);
        start8 = 1'b1;
        x8 = 16'h8000;
        a = cyc + 1;
        @(negedge clk);
        start8 = 1'b0;
        while (cyc < a + 7) @(negedge clk);
        check("term4_lut_adr", 32'(lut_adr8), 32'd3);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrun");
        @(negedge clk);
        rst = 1'b0;
        run8(16'h8000, 18'h1A60D);

        // Single-term instance
        run1(16'h8000, 18'h17FFF);
        run1(16'h0000, 18'h10000);
        run1(16'hFFFF, 18'h1FFFE);

        repeat (3) @(negedge clk);
        while (q8.size() > 0) begin
            void'(q8.pop_front());
            checks++;
            errors++;
            $display("FAIL pending8: got no done expected a completion");
        end
        while (q1.size() > 0) begin
            void'(q1.pop_front());
            checks++;
            errors++;
            $display("FAIL pending1: got no done expected a completion");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
